activity_led_multi: RTL and testbench

Multi-channel activity LED driver for the board status LEDs. Each channel turns a single-cycle activity pulse into a human-visible burst of N blinks, with fixed on/off phase length. Each trigger carries a per-channel blink count. A trigger that arrives while a burst is running is queued, so activity is never silently lost. There is also a continuous-blink hold input. The block sits between the accelerator status/handshake logic (trigger sources) and the top-level LED pins.

---
 rtl/activity_led_multi.sv | 143 ++++++++++++++
 tb/tb_activity_led_multi.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/activity_led_multi.sv
// rtl/activity_led_multi.sv - multi-channel activity LED burst driver
//
// Purpose: turns single-cycle activity pulses into bursts of N visible blinks
// per channel, with equal ON/OFF phases of HALF_PERIOD cycles. A trigger that
// arrives mid-burst is queued (last one wins); hold keeps a channel blinking.
//
// Ports:
//   clk          clock
//   rst_n        asynchronous active-low reset
//   trigger      [NUM_CH]            per-channel activity pulse
//   blink_count  [NUM_CH*BLINK_W]    blink count, channel i at [i*BLINK_W +: BLINK_W]
//   hold         [NUM_CH]            continuous blink request
//   led_out      [NUM_CH]            LED drive (polarity set by ACTIVE_HIGH)
//   busy         [NUM_CH]            channel is running a burst
module activity_led_multi #(
  parameter int NUM_CH      = 4,
  parameter int HALF_PERIOD = 12_500_000,
  parameter int CNT_WIDTH   = 24,
  parameter int BLINK_W     = 3,
  parameter int ACTIVE_HIGH = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_CH-1:0]           trigger,
  input  logic [NUM_CH*BLINK_W-1:0]   blink_count,
  input  logic [NUM_CH-1:0]           hold,
  output logic [NUM_CH-1:0]           led_out,
  output logic [NUM_CH-1:0]           busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] PHASE_LOAD = CNT_WIDTH'(HALF_PERIOD - 1);
  localparam logic                 LED_INVERT = (ACTIVE_HIGH == 0);
  localparam logic [BLINK_W-1:0]   ONE        = BLINK_W'(1);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    state_t               state, state_nx;
    logic [CNT_WIDTH-1:0] phase, phase_nx;
    logic [BLINK_W-1:0]   remaining, remaining_nx;
    logic [BLINK_W-1:0]   pend_cnt, pend_cnt_nx;
    logic                 pending, pending_nx;
    logic [BLINK_W-1:0]   count;
    logic                 start;
    logic                 phase_end;

    assign count     = blink_count[i*BLINK_W +: BLINK_W];
    // A zero-count trigger carries no work and is treated as no trigger.
    assign start     = trigger[i] && (count != '0);
    assign phase_end = (phase == '0);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state     <= IDLE;
        phase     <= '0;
        remaining <= '0;
        pending   <= 1'b0;
        pend_cnt  <= '0;
      end else begin
        state     <= state_nx;
        phase     <= phase_nx;
        remaining <= remaining_nx;
        pending   <= pending_nx;
        pend_cnt  <= pend_cnt_nx;
      end
    end

    always_comb begin
      state_nx     = state;
      phase_nx     = phase;
      remaining_nx = remaining;
      pending_nx   = pending;
      pend_cnt_nx  = pend_cnt;

      // Any running channel queues a new trigger; the restart branches
      // below override this when the trigger is consumed immediately.
      if (state != IDLE && start) begin
        pending_nx  = 1'b1;
        pend_cnt_nx = count;
      end

      case (state)
        IDLE: begin
          if (start) begin
            state_nx     = ON;
            phase_nx     = PHASE_LOAD;
            remaining_nx = count;
          end else if (hold[i]) begin
            state_nx     = ON;
            phase_nx     = PHASE_LOAD;
            remaining_nx = ONE;
          end
        end
        ON: begin
          if (phase_end) begin
            state_nx = OFF;
            phase_nx = PHASE_LOAD;
          end else begin
            phase_nx = phase - 1'b1;
          end
        end
        OFF: begin
          if (!phase_end) begin
            phase_nx = phase - 1'b1;
          end else if (hold[i]) begin
            state_nx = ON;
            phase_nx = PHASE_LOAD;
          end else if (remaining > ONE) begin
            state_nx     = ON;
            phase_nx     = PHASE_LOAD;
            remaining_nx = remaining - 1'b1;
          end else if (start) begin
            // Trigger on the last OFF cycle restarts directly, superseding
            // any older queued count.
            state_nx     = ON;
            phase_nx     = PHASE_LOAD;
            remaining_nx = count;
            pending_nx   = 1'b0;
          end else if (pending) begin
            state_nx     = ON;
            phase_nx     = PHASE_LOAD;
            remaining_nx = pend_cnt;
            pending_nx   = 1'b0;
          end else begin
            state_nx = IDLE;
          end
        end
        default: begin
          state_nx = IDLE;
          phase_nx = '0;
        end
      endcase
    end

    assign led_out[i] = (state == ON) ^ LED_INVERT;
    assign busy[i]    = (state != IDLE);
  end

endmodule

// File: tb/tb_activity_led_multi.sv
// tb/tb_activity_led_multi.sv - scoreboard bench for activity_led_multi
module tb_activity_led_multi;

  localparam int HP  = 4;
  localparam int NCH = 4;
  localparam int BW  = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NCH-1:0]    trigger = '0;
  logic [NCH*BW-1:0] blink_count = '0;
  logic [NCH-1:0]    hold = '0;
  logic [NCH-1:0]    led_out, busy;
  logic [NCH-1:0]    led_out_n, busy_n;

  always #5 clk = ~clk;

  activity_led_multi #(
    .NUM_CH(NCH), .HALF_PERIOD(HP), .CNT_WIDTH(4), .BLINK_W(BW), .ACTIVE_HIGH(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .trigger(trigger), .blink_count(blink_count),
    .hold(hold), .led_out(led_out), .busy(busy)
  );

  activity_led_multi #(
    .NUM_CH(NCH), .HALF_PERIOD(HP), .CNT_WIDTH(4), .BLINK_W(BW), .ACTIVE_HIGH(0)
  ) dut_n (
    .clk(clk), .rst_n(rst_n), .trigger(trigger), .blink_count(blink_count),
    .hold(hold), .led_out(led_out_n), .busy(busy_n)
  );

  typedef struct packed {
    logic [NCH-1:0] led;
    logic [NCH-1:0] busy;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   busy_cycles[NCH];

  // Reference model: a burst is a sequence of blinks, each 2*HP cycles long,
  // tracked by the cycle index inside the current blink.
  int   m_active[NCH];
  int   m_t[NCH];
  int   m_left[NCH];
  int   m_pend[NCH];

  task automatic check(input string name, input logic [NCH-1:0] act, input logic [NCH-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%b required=%b at %0t", name, act, req, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_step(output exp_t e);
    for (int ch = 0; ch < NCH; ch++) begin
      int  c;
      bit  v, h;
      c = int'(blink_count[ch*BW +: BW]);
      v = trigger[ch] && (c != 0);
      h = hold[ch];
      if (!rst_n) begin
        m_active[ch] = 0; m_t[ch] = 0; m_left[ch] = 0; m_pend[ch] = 0;
      end else if (m_active[ch] == 0) begin
        if (v) begin
          m_active[ch] = 1; m_t[ch] = 0; m_left[ch] = c;
        end else if (h) begin
          m_active[ch] = 1; m_t[ch] = 0; m_left[ch] = 1;
        end
      end else if (m_t[ch] == 2*HP-1) begin
        if (h) begin
          m_t[ch] = 0;
          if (v) m_pend[ch] = c;
        end else if (m_left[ch] > 1) begin
          m_left[ch]--; m_t[ch] = 0;
          if (v) m_pend[ch] = c;
        end else if (v) begin
          m_t[ch] = 0; m_left[ch] = c; m_pend[ch] = 0;
        end else if (m_pend[ch] != 0) begin
          m_t[ch] = 0; m_left[ch] = m_pend[ch]; m_pend[ch] = 0;
        end else begin
          m_active[ch] = 0;
        end
      end else begin
        m_t[ch]++;
        if (v) m_pend[ch] = c;
      end
      e.led[ch]  = (m_active[ch] != 0) && (m_t[ch] < HP);
      e.busy[ch] = (m_active[ch] != 0);
    end
  endtask

  function automatic logic [NCH*BW-1:0] cnt_at(input int ch, input int c);
    logic [NCH*BW-1:0] r;
    r = '0;
    r[ch*BW +: BW] = BW'(c);
    return r;
  endfunction

  // Drive one cycle of inputs on the falling edge and queue the response
  // expected after the following rising edge.
  task automatic step(input logic [NCH-1:0] trg, input logic [NCH*BW-1:0] cnt,
                      input logic [NCH-1:0] hld, input logic rst);
    exp_t e;
    @(negedge clk);
    trigger     = trg;
    blink_count = cnt;
    hold        = hld;
    rst_n       = rst;
    model_step(e);
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) step('0, '0, '0, 1'b1);
  endtask

  task automatic drain();
    @(posedge clk);
    #2;
  endtask

  initial begin
    for (int ch = 0; ch < NCH; ch++) busy_cycles[ch] = 0;
    forever begin
      exp_t e;
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        check("led_out", led_out, e.led);
        check("busy", busy, e.busy);
        check("led_out_low_polarity", led_out_n, ~e.led);
        check("busy_low_polarity", busy_n, e.busy);
        for (int ch = 0; ch < NCH; ch++)
          if (busy[ch]) busy_cycles[ch]++;
      end
    end
  end

  initial begin
    int b0;
    logic [NCH-1:0]    trg, hs;
    logic [NCH*BW-1:0] cnt;

    for (int ch = 0; ch < NCH; ch++) begin
      m_active[ch] = 0; m_t[ch] = 0; m_left[ch] = 0; m_pend[ch] = 0;
    end

    repeat (3) step('0, '0, '0, 1'b0);
    drain();
    check("reset_led", led_out, 4'b0000);
    check("reset_busy", busy, 4'b0000);
    check("reset_led_low_polarity", led_out_n, 4'b1111);

    // Two blinks on channel 0.
    b0 = busy_cycles[0];
    step(4'b0001, cnt_at(0, 2), '0, 1'b1);
    idle(22);
    drain();
    check_int("burst2_busy_len", busy_cycles[0] - b0, 16);

    // Queued trigger on channel 1 follows back-to-back.
    b0 = busy_cycles[1];
    step(4'b0010, cnt_at(1, 1), '0, 1'b1);
    idle(1);
    step(4'b0010, cnt_at(1, 3), '0, 1'b1);
    idle(36);
    drain();
    check_int("queued_busy_len", busy_cycles[1] - b0, 32);

    // Re-trigger exactly on the final OFF cycle of channel 2.
    b0 = busy_cycles[2];
    step(4'b0100, cnt_at(2, 1), '0, 1'b1);
    idle(7);
    step(4'b0100, cnt_at(2, 2), '0, 1'b1);
    idle(30);
    drain();
    check_int("final_off_retrigger_busy_len", busy_cycles[2] - b0, 24);

    // Zero count is ignored; then hold for 20 cycles on channel 3.
    b0 = busy_cycles[3];
    step(4'b1000, cnt_at(3, 0), '0, 1'b1);
    idle(3);
    repeat (20) step('0, '0, 4'b1000, 1'b1);
    idle(20);
    drain();
    check_int("hold_busy_len", busy_cycles[3] - b0, 24);
    check("hold_ends_idle", busy, 4'b0000);

    // Reset mid-ON with a pending burst; nothing may replay afterwards.
    step(4'b0001, cnt_at(0, 2), '0, 1'b1);
    idle(1);
    step(4'b0001, cnt_at(0, 3), '0, 1'b1);
    step('0, '0, '0, 1'b0);
    #1;
    check("async_reset_led", led_out, 4'b0000);
    check("async_reset_busy", busy, 4'b0000);
    check("async_reset_led_low_polarity", led_out_n, 4'b1111);
    step('0, '0, '0, 1'b0);
    b0 = busy_cycles[0];
    idle(40);
    drain();
    check_int("no_replay_after_reset", busy_cycles[0] - b0, 0);

    // Randomized traffic on all channels.
    hs = '0;
    for (int n = 0; n < 800; n++) begin
      for (int ch = 0; ch < NCH; ch++) begin
        trg[ch] = ($urandom_range(0, 11) == 0);
        if ($urandom_range(0, 59) == 0) hs[ch] = ~hs[ch];
      end
      cnt = NCH*BW'($urandom);
      step(trg, cnt, hs, 1'b1);
    end
    idle(150);
    drain();
    check("random_ends_idle", busy, 4'b0000);
    check_int("scoreboard_empty", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
